interleave_lane_merger: RTL and testbench

//  Consumer end of a two-lane interleaved stream: accepts lane 0 and lane 1 valid-ready

---
 rtl/interleave_lane_merger_pkg.sv | 24 ++
 rtl/interleave_lane_merger_lane_hold_reg.sv | 51 +++++
 rtl/interleave_lane_merger.sv | 136 +++++++++++++
 tb/tb_interleave_lane_merger.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/interleave_lane_merger_pkg.sv
// Shared types for the two-lane interleave splitter/merger pair.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package interleave_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } merge_state_e;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  // Width able to hold 0..timeout, never narrower than one bit.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/interleave_lane_merger_lane_hold_reg.sv
// One-entry valid-ready hold register for one lane; the consumer pops it explicitly.
// Latency: a word accepted at an edge is visible on hold_valid/hold_data the next cycle.
// Backpressure: in_ready = empty or being popped this cycle, forced low while blocked.
module lane_hold_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  pop,
  input  logic                  blocked,
  output logic                  hold_valid,
  output logic [DATA_WIDTH-1:0] hold_data
);

  logic                  hv_q, hv_d;
  logic [DATA_WIDTH-1:0] hd_q, hd_d;
  logic                  accept;

  // Accept/pop decision: a simultaneous accept and pop replaces the word and stays full.
  always_comb begin
    in_ready = (!hv_q || pop) && !blocked;
    accept   = in_valid && in_ready;
    hv_d     = hv_q;
    hd_d     = hd_q;
    if (accept) begin
      hv_d = 1'b1;
      hd_d = in_data;
    end else if (pop) begin
      hv_d = 1'b0;
    end
  end

  // Hold register; rst and clear both drop any held word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hv_q <= 1'b0;
      hd_q <= '0;
    end else begin
      hv_q <= hv_d;
      hd_q <= hd_d;
    end
  end

  assign hold_valid = hv_q;
  assign hold_data  = hd_q;

endmodule

// File: rtl/interleave_lane_merger.sv
// Re-merges two half-rate lanes into one stream in strict L0,L1,L0,... order; flags a stuck lane.
// Latency: 1 cycle lane-to-output (output is a combinational mux of the hold registers).
// Backpressure: out_ready low holds the selected word; lane readies fall once their hold is full.
module interleave_lane_merger #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] lane0_data,
  input  logic                  lane0_valid,
  output logic                  lane0_ready,
  input  logic [DATA_WIDTH-1:0] lane1_data,
  input  logic                  lane1_valid,
  output logic                  lane1_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_lane,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic                  err_order
);

  import interleave_pkg::*;

  localparam int TW = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  merge_state_e          state_q, state_d;
  lane_e                 sel_q, sel_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  hv0, hv1;
  logic [DATA_WIDTH-1:0] hd0, hd1;
  logic                  hv_sel, hv_oth;
  logic                  xfer, pop0, pop1, blocked;

  lane_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold0 (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_data    (lane0_data),
    .in_valid   (lane0_valid),
    .in_ready   (lane0_ready),
    .pop        (pop0),
    .blocked    (blocked),
    .hold_valid (hv0),
    .hold_data  (hd0)
  );

  lane_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold1 (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_data    (lane1_data),
    .in_valid   (lane1_valid),
    .in_ready   (lane1_ready),
    .pop        (pop1),
    .blocked    (blocked),
    .hold_valid (hv1),
    .hold_data  (hd1)
  );

  // State register for the FSM and all merge bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= ST_RUN;
      sel_q   <= LANE0;
      timer_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state: stall when the expected lane is empty but the other lane already holds a word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (!hv_sel && hv_oth) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (hv_sel) begin
          state_d = ST_RUN;
        end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs: lane mux, handshake, pops and the error gating of both readies.
  always_comb begin
    hv_sel    = (sel_q == LANE1) ? hv1 : hv0;
    hv_oth    = (sel_q == LANE1) ? hv0 : hv1;
    out_data  = (sel_q == LANE1) ? hd1 : hd0;
    out_lane  = sel_q;
    blocked   = (state_q == ST_ERR);
    out_valid = hv_sel && !blocked;
    xfer      = out_valid && out_ready;
    pop0      = xfer && (sel_q == LANE0);
    pop1      = xfer && (sel_q == LANE1);
  end

  // Datapath next values: alternate lanes per transfer, count transfers, time the wait.
  always_comb begin
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    timer_d = '0;
    err_d   = (state_d == ST_ERR);
    if (xfer) begin
      sel_d = (sel_q == LANE0) ? LANE1 : LANE0;
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    if ((state_q == ST_WAIT) && (state_d != ST_RUN)) begin
      timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
    end
  end

  assign xfer_count = cnt_q;
  assign err_order  = err_q;

endmodule

// File: tb/tb_interleave_lane_merger.sv
// Randomized bench comparing two merger configurations against a stream-level reference model.
// Latency: model outputs are compared every cycle, one time unit after the input-driving negedge.
// Backpressure: out_ready and lane valids are driven from directed sequences and random mixes.
module tb_interleave_lane_merger;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clear;
  logic [7:0] l0_dat, l1_dat;
  logic       l0_vld, l1_vld, o_rdy;

  logic       rdy0 [2];
  logic       rdy1 [2];
  logic       ovld [2];
  logic       olane[2];
  logic       oerr [2];
  logic [7:0] odat [2];
  logic [3:0] a_cnt;
  logic [15:0] b_cnt;

  // Instance 0: narrow counter, short timeout. Instance 1: timeout disabled.
  interleave_lane_merger #(.DATA_WIDTH(8), .CNT_WIDTH(4), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .clear(clear),
    .lane0_data(l0_dat), .lane0_valid(l0_vld), .lane0_ready(rdy0[0]),
    .lane1_data(l1_dat), .lane1_valid(l1_vld), .lane1_ready(rdy1[0]),
    .out_data(odat[0]), .out_valid(ovld[0]), .out_ready(o_rdy),
    .out_lane(olane[0]), .xfer_count(a_cnt), .err_order(oerr[0])
  );

  interleave_lane_merger #(.DATA_WIDTH(8), .CNT_WIDTH(16), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear),
    .lane0_data(l0_dat), .lane0_valid(l0_vld), .lane0_ready(rdy0[1]),
    .lane1_data(l1_dat), .lane1_valid(l1_vld), .lane1_ready(rdy1[1]),
    .out_data(odat[1]), .out_valid(ovld[1]), .out_ready(o_rdy),
    .out_lane(olane[1]), .xfer_count(b_cnt), .err_order(oerr[1])
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each lane is a one-word buffer, output alternates lanes starting at lane 0,
  // and a lane error fires once the expected lane has been starved for TIMEOUT+1 consecutive
  // cycles while the other lane is already waiting.
  bit         m_ok = 1'b0;
  bit         m_hv [2][2];
  logic [7:0] m_hd [2][2];
  int         m_sel[2];
  int         m_cnt[2];
  int         m_stall[2];
  bit         m_err[2];
  int         tmo  [2];
  int         cmask[2];

  bit         e_rdy [2][2];
  bit         e_pop [2][2];
  bit         e_xfer[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        m_hv[k][i] = 1'b0;
        m_hd[k][i] = 8'h00;
      end
      m_sel[k] = 0; m_cnt[k] = 0; m_stall[k] = 0; m_err[k] = 1'b0;
    end
  endtask

  task automatic do_cycle(input bit r, input bit c, input bit v0, input logic [7:0] d0,
                          input bit v1, input logic [7:0] d1, input bit ordy);
    logic [31:0] got_cnt;
    bit          exp_vld;
    bit          stall;
    @(negedge clk);
    rst = r; clear = c; l0_vld = v0; l0_dat = d0; l1_vld = v1; l1_dat = d1; o_rdy = ordy;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_vld   = m_hv[k][m_sel[k]] && !m_err[k];
      e_xfer[k] = exp_vld && ordy;
      for (int i = 0; i < 2; i++) begin
        e_pop[k][i] = e_xfer[k] && (m_sel[k] == i);
        e_rdy[k][i] = (!m_hv[k][i] || e_pop[k][i]) && !m_err[k];
      end
      if (m_ok) begin
        got_cnt = (k == 0) ? {28'd0, a_cnt} : {16'd0, b_cnt};
        check_eq($sformatf("out_valid[%0d]", k), 32'(ovld[k]), 32'(exp_vld));
        if (exp_vld)
          check_eq($sformatf("out_data[%0d]", k), 32'(odat[k]), 32'(m_hd[k][m_sel[k]]));
        check_eq($sformatf("out_lane[%0d]", k), 32'(olane[k]), 32'(m_sel[k]));
        check_eq($sformatf("lane0_ready[%0d]", k), 32'(rdy0[k]), 32'(e_rdy[k][0]));
        check_eq($sformatf("lane1_ready[%0d]", k), 32'(rdy1[k]), 32'(e_rdy[k][1]));
        check_eq($sformatf("xfer_count[%0d]", k), got_cnt, 32'(m_cnt[k]));
        check_eq($sformatf("err_order[%0d]", k), 32'(oerr[k]), 32'(m_err[k]));
      end
    end
    @(posedge clk);
    if (r || c) begin
      model_reset();
      m_ok = 1'b1;
    end else if (m_ok) begin
      for (int k = 0; k < 2; k++) begin
        if (!m_err[k]) begin
          stall = !m_hv[k][m_sel[k]] && m_hv[k][1 - m_sel[k]];
          m_stall[k] = stall ? m_stall[k] + 1 : 0;
          if ((tmo[k] != 0) && (m_stall[k] == tmo[k] + 1)) m_err[k] = 1'b1;
        end
        if (v0 && e_rdy[k][0]) begin
          m_hv[k][0] = 1'b1; m_hd[k][0] = d0;
        end else if (e_pop[k][0]) begin
          m_hv[k][0] = 1'b0;
        end
        if (v1 && e_rdy[k][1]) begin
          m_hv[k][1] = 1'b1; m_hd[k][1] = d1;
        end else if (e_pop[k][1]) begin
          m_hv[k][1] = 1'b0;
        end
        if (e_xfer[k]) begin
          m_sel[k] = 1 - m_sel[k];
          m_cnt[k] = (m_cnt[k] + 1) & cmask[k];
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, ordy);
  endtask

  task automatic random_run(input int n, input int p_v0, input int p_v1, input int p_rdy,
                            input int p_clr);
    for (int i = 0; i < n; i++)
      do_cycle(1'b0, ($urandom_range(999, 0) < p_clr),
               ($urandom_range(99, 0) < p_v0), 8'($urandom),
               ($urandom_range(99, 0) < p_v1), 8'($urandom),
               ($urandom_range(99, 0) < p_rdy));
  endtask

  initial begin
    tmo[0] = 8;  tmo[1] = 0;
    cmask[0] = 32'h000F; cmask[1] = 32'hFFFF;
    rst = 1'b1; clear = 1'b0; l0_vld = 1'b0; l1_vld = 1'b0;
    l0_dat = 8'h00; l1_dat = 8'h00; o_rdy = 1'b0;

    // Reset, then reset values checked while rst is still held.
    do_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(2, 1'b1);

    // Simple in-order stream 11,22,33.
    do_cycle(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    idle(3, 1'b1);

    // Both lanes offered under a 5-cycle stall, then drain.
    for (int i = 0; i < 6; i++)
      do_cycle(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 6; i++)
      do_cycle(1'b0, 1'b0, 1'b1, 8'(8'h50 + i), 1'b1, 8'(8'h90 + i), 1'b1);
    idle(4, 1'b1);

    // Lane 1 arrives early, lane 0 late: order must be restored.
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b1);
    idle(2, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    idle(3, 1'b1);

    // Clear with both holds full and output valid; lane 0 must lead afterwards.
    do_cycle(1'b0, 1'b0, 1'b1, 8'hC0, 1'b1, 8'hC1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hD1, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b1, 8'hD0, 1'b0, 8'h00, 1'b1);
    idle(3, 1'b1);

    // Lane 0 silent for 1000 cycles: short-timeout instance errors, disabled one never does.
    do_cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 1000; i++)
      do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'($urandom), 1'b1);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(2, 1'b1);

    // Ideal half-rate alternation: full throughput and counter wrap on the 4-bit instance.
    for (int i = 0; i < 40; i++)
      do_cycle(1'b0, 1'b0, (i % 2 == 0), 8'($urandom), (i % 2 == 1), 8'($urandom), 1'b1);
    idle(3, 1'b1);

    // Random traffic: busy, back-pressured, and occasional clears.
    random_run(600, 70, 70, 80, 4);
    random_run(600, 50, 50, 30, 4);
    random_run(600, 15, 60, 90, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
